// File: rtl/crank_decoder_if.sv
// Crank decoder signal bundle: sensor/enable inputs and the trigger, phase,
// sync and period outputs.
interface crank_decoder_if #(
    parameter int PERIOD_W = 32
);
    logic                en;
    logic                crank_in;
    logic                trigger;
    logic [15:0]         eng_phase;
    logic                synced;
    logic                sync_loss;
    logic [PERIOD_W-1:0] tooth_period;

    modport master (
        output en, crank_in,
        input  trigger, eng_phase, synced, sync_loss, tooth_period
    );

    modport slave (
        input  en, crank_in,
        output trigger, eng_phase, synced, sync_loss, tooth_period
    );
endinterface

// File: rtl/crank_decoder.sv
// Missing-tooth crank wheel decoder: synchronizes and debounces the sensor,
// measures tooth periods, detects the gap and emits per-tooth trigger/phase.
//
// state  | meaning
// IDLE   | disabled, reset or stalled; waiting for a first edge
// HUNT   | have a reference period, looking for the gap
// SYNCED | locked to the wheel; eng_phase tracks the tooth index
module crank_decoder #(
    parameter int TEETH_TOTAL   = 36,
    parameter int TEETH_MISSING = 1,
    parameter int PERIOD_W      = 32,
    parameter int GAP_NUM       = 3,
    parameter int GAP_DEN       = 2,
    parameter int DEBOUNCE      = 4,
    parameter int STALL_CYCLES  = 2**24
) (
    input logic           clk,
    input logic           rst,
    crank_decoder_if.slave bus
);
    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int PROD_W = PERIOD_W + 8;
    localparam logic [CNT_W-1:0]    DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [PERIOD_W-1:0] STALL_VAL = PERIOD_W'(STALL_CYCLES);
    localparam logic [15:0]         LAST_IDX  = 16'(TEETH_TOTAL - TEETH_MISSING - 1);

    typedef enum logic [1:0] {IDLE, HUNT, SYNCED} state_t;

    state_t              state, state_nx;
    logic                sync_meta, sync_q, filt_level, edge_acc;
    logic [CNT_W-1:0]    filt_cnt;
    logic [PERIOD_W-1:0] period_cnt, prev_period, captured;
    logic [PERIOD_W-1:0] prev_nx, tp_nx;
    logic [15:0]         phase_nx;
    logic                trig_nx, loss_nx, gap, stall;
    logic [PROD_W-1:0]   cur_x, prev_x;

    // Level filter: the level only flips after DEBOUNCE consecutive opposite samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            filt_level <= 1'b0;
            filt_cnt   <= '0;
            edge_acc   <= 1'b0;
        end else begin
            sync_meta <= bus.crank_in;
            sync_q    <= sync_meta;
            edge_acc  <= 1'b0;
            if (sync_q != filt_level) begin
                if (filt_cnt == DEB_LAST) begin
                    filt_level <= sync_q;
                    filt_cnt   <= '0;
                    edge_acc   <= sync_q;
                end else begin
                    filt_cnt <= filt_cnt + CNT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (edge_acc) begin
            period_cnt <= '0;
        end else if (period_cnt != '1) begin
            period_cnt <= period_cnt + PERIOD_W'(1);
        end
    end

    assign captured = (period_cnt == '1) ? period_cnt : period_cnt + PERIOD_W'(1);
    assign stall    = (period_cnt >= STALL_VAL);
    assign cur_x    = PROD_W'(captured) * PROD_W'(GAP_DEN);
    assign prev_x   = PROD_W'(prev_period) * PROD_W'(GAP_NUM);
    assign gap      = (prev_period != '0) && (cur_x > prev_x);

    always_comb begin
        state_nx = state;
        phase_nx = bus.eng_phase;
        trig_nx  = 1'b0;
        loss_nx  = 1'b0;
        prev_nx  = prev_period;
        tp_nx    = bus.tooth_period;
        if (!bus.en) begin
            state_nx = IDLE;
            prev_nx  = '0;
        end else if (edge_acc) begin
            // An edge always wins over a simultaneous stall.
            prev_nx = captured;
            if (state != IDLE)
                tp_nx = captured;
            case (state)
                IDLE: state_nx = HUNT;
                HUNT: begin
                    if (gap) begin
                        state_nx = SYNCED;
                        phase_nx = '0;
                        trig_nx  = 1'b1;
                    end
                end
                SYNCED: begin
                    if (bus.eng_phase == LAST_IDX) begin
                        if (gap) begin
                            phase_nx = '0;
                            trig_nx  = 1'b1;
                        end else begin
                            state_nx = HUNT;
                            loss_nx  = 1'b1;
                        end
                    end else if (!gap) begin
                        phase_nx = bus.eng_phase + 16'd1;
                        trig_nx  = 1'b1;
                    end else begin
                        state_nx = HUNT;
                        loss_nx  = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (stall) begin
            state_nx = IDLE;
            prev_nx  = '0;
            loss_nx  = (state == SYNCED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            prev_period      <= '0;
            bus.trigger      <= 1'b0;
            bus.eng_phase    <= '0;
            bus.synced       <= 1'b0;
            bus.sync_loss    <= 1'b0;
            bus.tooth_period <= '0;
        end else begin
            state            <= state_nx;
            prev_period      <= prev_nx;
            bus.trigger      <= trig_nx;
            bus.eng_phase    <= phase_nx;
            bus.synced       <= (state_nx == SYNCED);
            bus.sync_loss    <= loss_nx;
            bus.tooth_period <= tp_nx;
        end
    end
endmodule

// File: tb/tb_crank_decoder.sv
// Directed bench for crank_decoder on an 8-position wheel with one missing tooth.
module tb_crank_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic        t_trg, t_early, t_loss, t_synced;
    logic [15:0] t_ph;
    logic [31:0] t_tp, t_tp_end;
    int          t_ntrig, t_nloss;

    crank_decoder_if #(.PERIOD_W(32)) bus ();

    crank_decoder #(
        .TEETH_TOTAL(8), .TEETH_MISSING(1), .PERIOD_W(32), .GAP_NUM(3),
        .GAP_DEN(2), .DEBOUNCE(2), .STALL_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One tooth: rise now, high 30 clks, next rise 'period' clks later.
    task automatic tooth(input int period, input int glitch);
        bus.crank_in = 1'b1;
        t_ntrig = 0;
        t_nloss = 0;
        t_early = 1'b0;
        for (int c = 1; c <= period; c++) begin
            @(posedge clk); #1;
            if (c == 30) bus.crank_in = 1'b0;
            if (glitch != 0 && c == glitch) bus.crank_in = 1'b1;
            if (glitch != 0 && c == glitch + 1) bus.crank_in = 1'b0;
            if (bus.trigger) t_ntrig++;
            if (bus.sync_loss) t_nloss++;
            if (c == 4) t_early = bus.trigger;
            if (c == 5) begin
                t_trg    = bus.trigger;
                t_loss   = bus.sync_loss;
                t_ph     = bus.eng_phase;
                t_tp     = bus.tooth_period;
                t_synced = bus.synced;
            end
        end
        t_tp_end = bus.tooth_period;
    endtask

    task automatic no_trig(input string name);
        total++;
        if (t_ntrig !== 0) begin
            bad++;
            $display("FAIL %s triggers got %0d want 0", name, t_ntrig);
        end
        total++;
        if (t_synced !== 1'b0) begin
            bad++;
            $display("FAIL %s synced got %0b want 0", name, t_synced);
        end
    endtask

    task automatic rev(input int start, input int glitch_idx, input int last_p, input string name);
        for (int i = start; i < 7; i++) begin
            tooth((i == 6) ? last_p : 100, (i == glitch_idx) ? 60 : 0);
            total++;
            if (t_early !== 1'b0 || t_trg !== 1'b1) begin
                bad++;
                $display("FAIL %s latency i=%0d early=%0b at5=%0b want 0/1", name, i, t_early, t_trg);
            end
            total++;
            if (t_ph !== 16'(i)) begin
                bad++;
                $display("FAIL %s eng_phase got %0d want %0d", name, t_ph, i);
            end
            total++;
            if (t_tp !== ((i == 0) ? 32'd200 : 32'd100)) begin
                bad++;
                $display("FAIL %s tooth_period i=%0d got %0d want %0d", name, i, t_tp, (i == 0) ? 200 : 100);
            end
            total++;
            if (t_ntrig !== 1 || t_nloss !== 0 || t_synced !== 1'b1) begin
                bad++;
                $display("FAIL %s i=%0d trig=%0d loss=%0d synced=%0b want 1/0/1", name, i, t_ntrig, t_nloss, t_synced);
            end
            if (i == glitch_idx) begin
                total++;
                if (t_tp_end !== 32'd100) begin
                    bad++;
                    $display("FAIL %s glitch tooth_period got %0d want 100", name, t_tp_end);
                end
            end
        end
    endtask

    task automatic test_reset;
        bus.en = 1'b1;
        bus.crank_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.trigger, bus.synced, bus.sync_loss} !== 3'b000 || bus.eng_phase !== 16'd0 || bus.tooth_period !== 32'd0) begin
            bad++;
            $display("FAIL reset outputs trg=%0b syn=%0b loss=%0b ph=%0d tp=%0d want all 0",
                     bus.trigger, bus.synced, bus.sync_loss, bus.eng_phase, bus.tooth_period);
        end
        rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        total++;
        if (bus.trigger !== 1'b0 || bus.synced !== 1'b0) begin
            bad++;
            $display("FAIL reset idle trg=%0b syn=%0b want 0/0", bus.trigger, bus.synced);
        end
    endtask

    task automatic test_sync;
        tooth(100, 0); no_trig("sync_e1");
        tooth(100, 0); no_trig("sync_e2");
        tooth(200, 0); no_trig("sync_e3");
        rev(0, -1, 200, "sync_rev1");
        rev(0, -1, 200, "sync_rev2");
    endtask

    task automatic test_glitch;
        rev(0, 2, 200, "glitch");
    endtask

    task automatic test_extra_tooth;
        rev(0, -1, 100, "extra_pre");
        tooth(200, 0);
        total++;
        if (t_loss !== 1'b1 || t_nloss !== 1 || t_ntrig !== 0 || t_synced !== 1'b0) begin
            bad++;
            $display("FAIL extra loss=%0b nloss=%0d trig=%0d synced=%0b want 1/1/0/0",
                     t_loss, t_nloss, t_ntrig, t_synced);
        end
        rev(0, -1, 200, "extra_resync");
    endtask

    task automatic test_stall;
        int nloss = 0;
        int ntrig = 0;
        for (int c = 0; c < 1200; c++) begin
            @(posedge clk); #1;
            if (bus.sync_loss) nloss++;
            if (bus.trigger) ntrig++;
        end
        total++;
        if (nloss !== 1 || ntrig !== 0 || bus.synced !== 1'b0) begin
            bad++;
            $display("FAIL stall nloss=%0d trig=%0d synced=%0b want 1/0/0", nloss, ntrig, bus.synced);
        end
        total++;
        if (bus.tooth_period !== 32'd100 || bus.eng_phase !== 16'd6) begin
            bad++;
            $display("FAIL stall retain tp=%0d ph=%0d want 100/6", bus.tooth_period, bus.eng_phase);
        end
        tooth(100, 0); no_trig("stall_e1");
        tooth(200, 0); no_trig("stall_e2");
        rev(0, -1, 200, "stall_resync");
    endtask

    task automatic test_enable;
        int nloss = 0;
        int ntrig = 0;
        bus.en = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.synced !== 1'b0 || bus.sync_loss !== 1'b0) begin
            bad++;
            $display("FAIL en_low synced=%0b loss=%0b want 0/0", bus.synced, bus.sync_loss);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.sync_loss) nloss++;
            if (bus.trigger) ntrig++;
        end
        total++;
        if (nloss !== 0 || ntrig !== 0) begin
            bad++;
            $display("FAIL en_low pulses loss=%0d trig=%0d want 0/0", nloss, ntrig);
        end
        bus.en = 1'b1;
        tooth(100, 0); no_trig("en_e1");
        tooth(200, 0); no_trig("en_e2");
        rev(0, -1, 200, "en_resync");
    endtask

    task automatic test_mid_reset;
        rst = 1'b1;
        #2;
        total++;
        if ({bus.trigger, bus.synced, bus.sync_loss} !== 3'b000 || bus.eng_phase !== 16'd0 || bus.tooth_period !== 32'd0) begin
            bad++;
            $display("FAIL midreset outputs trg=%0b syn=%0b loss=%0b ph=%0d tp=%0d want all 0",
                     bus.trigger, bus.synced, bus.sync_loss, bus.eng_phase, bus.tooth_period);
        end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        tooth(100, 0); no_trig("mrst_e1");
        tooth(100, 0); no_trig("mrst_e2");
        tooth(200, 0); no_trig("mrst_e3");
        rev(0, -1, 200, "mrst_resync");
    endtask

    initial begin
        test_reset();
        test_sync();
        test_glitch();
        test_extra_tooth();
        test_stall();
        test_enable();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
